// File: rtl/isa_pkg.sv
// Purpose: shared RV32I-subset encodings, microcode entry points and decode record for the issue stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package isa_pkg;

    // Major opcodes of the supported subset
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;

    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_XOR = 3'b100;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    // Microcode entry addresses inside the column/row datapath
    localparam logic [4:0] UADDR_LOAD  = 5'd0;
    localparam logic [4:0] UADDR_STORE = 5'd2;
    localparam logic [4:0] UADDR_ADD   = 5'd4;
    localparam logic [4:0] UADDR_SUB   = 5'd6;
    localparam logic [4:0] UADDR_ADDI  = 5'd8;
    localparam logic [4:0] UADDR_AND   = 5'd10;
    localparam logic [4:0] UADDR_OR    = 5'd12;
    localparam logic [4:0] UADDR_XOR   = 5'd14;
    localparam logic [4:0] UADDR_JAL   = 5'd16;
    localparam logic [4:0] UADDR_WAIT  = 5'd18;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        HALT   = 2'd3
    } state_t;

    // One decoded instruction; imm is sign-extended to 32 bits here and widened by the consumer
    typedef struct packed {
        logic [4:0]  uaddr;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        is_jal;
        logic        illegal;
    } dec_fields_t;

endpackage

// File: rtl/instr_field_decode.sv
// Purpose: map one instruction word to microcode entry, register indices and immediate.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows input every cycle.
module instr_field_decode
    import isa_pkg::*;
(
    input  logic [31:0] instr,
    output dec_fields_t fields
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_j;

    assign opc   = instr[6:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    // Classify the word; anything outside the table is flagged illegal and keeps the wait entry
    always_comb begin
        fields         = '0;
        fields.uaddr   = UADDR_WAIT;
        fields.rd      = instr[11:7];
        fields.rs1     = instr[19:15];
        fields.rs2     = instr[24:20];
        fields.illegal = 1'b1;
        case (opc)
            OPC_LOAD: if (f3 == F3_LW) begin
                fields.uaddr   = UADDR_LOAD;
                fields.imm     = imm_i;
                fields.illegal = 1'b0;
            end
            OPC_STORE: if (f3 == F3_SW) begin
                fields.uaddr   = UADDR_STORE;
                fields.imm     = imm_s;
                fields.illegal = 1'b0;
            end
            OPC_OPIMM: if (f3 == F3_ADD) begin
                fields.uaddr   = UADDR_ADDI;
                fields.imm     = imm_i;
                fields.illegal = 1'b0;
            end
            OPC_OP: begin
                fields.illegal = 1'b0;
                if (f7 == F7_SUB && f3 == F3_ADD)         fields.uaddr = UADDR_SUB;
                else if (f7 != F7_BASE)                   fields.illegal = 1'b1;
                else if (f3 == F3_ADD)                    fields.uaddr = UADDR_ADD;
                else if (f3 == F3_AND)                    fields.uaddr = UADDR_AND;
                else if (f3 == F3_OR)                     fields.uaddr = UADDR_OR;
                else if (f3 == F3_XOR)                    fields.uaddr = UADDR_XOR;
                else                                      fields.illegal = 1'b1;
            end
            OPC_JAL: begin
                fields.uaddr   = UADDR_JAL;
                fields.imm     = imm_j;
                fields.is_jal  = 1'b1;
                fields.illegal = 1'b0;
            end
            default: fields.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_decode_seq.sv
// Purpose: fetch, decode and hold one instruction for the microcoded datapath, then advance the PC.
// Latency: fetch accept -> fields valid after 2 cycles (capture + decode); PC updates the cycle after done.
// Backpressure: instr_req held until instr_valid; fields held in EXEC until done or watchdog expiry.
module instr_decode_seq #(
    parameter int              COLS     = 32,
    parameter logic [COLS-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 64
) (
    input  logic            clk,
    input  logic            rst,
    output logic            instr_req,
    output logic [COLS-1:0] instr_addr,
    input  logic            instr_valid,
    input  logic [31:0]     instr_data,
    input  logic            done,
    output logic [4:0]      decode_addr,
    output logic [4:0]      rd_index,
    output logic [4:0]      rs1_index,
    output logic [4:0]      rs2_index,
    output logic [COLS-1:0] immediate,
    output logic [COLS-1:0] pc_reg,
    output logic [COLS-1:0] pc_plus4,
    output logic            illegal_instr,
    output logic            timeout_err,
    output logic            halted
);
    import isa_pkg::*;

    localparam int            WDW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    state_t          state;
    state_t          state_nxt;
    logic [31:0]     instr_q;
    dec_fields_t     dec;
    logic            is_jal_q;
    logic [WDW-1:0]  wd_cnt;
    logic            wd_expire;
    logic [COLS-1:0] pc_nxt;

    instr_field_decode u_field_decode (
        .instr  (instr_q),
        .fields (dec)
    );

    assign wd_expire  = (wd_cnt == WD_LAST);
    assign pc_nxt     = is_jal_q ? (pc_reg + immediate) : pc_plus4;
    assign instr_addr = pc_reg;

    // State register; reset always returns to FETCH, discarding any in-flight instruction
    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    // Next-state: done beats the watchdog boundary because it is tested first
    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:  if (instr_valid) state_nxt = DECODE;
            DECODE: state_nxt = dec.illegal ? FETCH : EXEC;
            EXEC: begin
                if (done)           state_nxt = FETCH;
                else if (wd_expire) state_nxt = HALT;
            end
            HALT:   state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        instr_req = (state == FETCH) && !rst;
        halted    = (state == HALT);
    end

    // Datapath: word capture, field registers, PC, watchdog and error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q       <= '0;
            pc_reg        <= RESET_PC;
            pc_plus4      <= RESET_PC + COLS'(4);
            decode_addr   <= UADDR_WAIT;
            rd_index      <= '0;
            rs1_index     <= '0;
            rs2_index     <= '0;
            immediate     <= '0;
            is_jal_q      <= 1'b0;
            wd_cnt        <= '0;
            illegal_instr <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            illegal_instr <= 1'b0;
            case (state)
                FETCH: if (instr_valid) instr_q <= instr_data;
                DECODE: begin
                    decode_addr <= dec.uaddr;
                    rd_index    <= dec.rd;
                    rs1_index   <= dec.rs1;
                    rs2_index   <= dec.rs2;
                    immediate   <= COLS'($signed(dec.imm));
                    is_jal_q    <= dec.is_jal;
                    wd_cnt      <= '0;
                    if (dec.illegal) begin
                        illegal_instr <= 1'b1;
                        pc_reg        <= pc_plus4;
                        pc_plus4      <= pc_plus4 + COLS'(4);
                    end
                end
                EXEC: begin
                    if (done) begin
                        decode_addr <= UADDR_WAIT;
                        pc_reg      <= pc_nxt;
                        pc_plus4    <= pc_nxt + COLS'(4);
                    end else if (wd_expire) begin
                        decode_addr <= UADDR_WAIT;
                        timeout_err <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_decode_seq.sv
// Purpose: randomized and directed checks of the issue stage against a behavioural ISA model.
// Latency: n/a.
// Backpressure: n/a.
module tb_instr_decode_seq;

    localparam int COLS    = 32;
    localparam int TIMEOUT = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            instr_req;
    logic [COLS-1:0] instr_addr;
    logic            instr_valid;
    logic [31:0]     instr_data;
    logic            done;
    logic [4:0]      decode_addr;
    logic [4:0]      rd_index;
    logic [4:0]      rs1_index;
    logic [4:0]      rs2_index;
    logic [COLS-1:0] immediate;
    logic [COLS-1:0] pc_reg;
    logic [COLS-1:0] pc_plus4;
    logic            illegal_instr;
    logic            timeout_err;
    logic            halted;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    instr_decode_seq #(.COLS(COLS), .RESET_PC(32'h0), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_valid(instr_valid), .instr_data(instr_data),
        .done(done),
        .decode_addr(decode_addr), .rd_index(rd_index), .rs1_index(rs1_index),
        .rs2_index(rs2_index), .immediate(immediate),
        .pc_reg(pc_reg), .pc_plus4(pc_plus4),
        .illegal_instr(illegal_instr), .timeout_err(timeout_err), .halted(halted)
    );

    // Reference: instruction table lookup with immediates computed as signed integers
    function automatic void ref_decode(input logic [31:0] w, output bit legal,
                                       output logic [4:0] ua, output logic [31:0] imm,
                                       output bit jal);
        int opc, f3, f7, ival, sval, jval;
        opc  = int'(w[6:0]);
        f3   = int'(w[14:12]);
        f7   = int'(w[31:25]);
        ival = int'(w[31:20]) - (w[31] ? 4096 : 0);
        sval = int'(w[31:25]) * 32 + int'(w[11:7]) - (w[31] ? 4096 : 0);
        jval = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2
               - (w[31] ? (1 << 20) : 0);
        legal = 1'b1; jal = 1'b0; imm = 32'd0; ua = 5'd18;
        if (opc == 'h03 && f3 == 2)                   begin ua = 5'd0;  imm = ival; end
        else if (opc == 'h23 && f3 == 2)              begin ua = 5'd2;  imm = sval; end
        else if (opc == 'h13 && f3 == 0)              begin ua = 5'd8;  imm = ival; end
        else if (opc == 'h33 && f7 == 32 && f3 == 0)  ua = 5'd6;
        else if (opc == 'h33 && f7 == 0 && f3 == 0)   ua = 5'd4;
        else if (opc == 'h33 && f7 == 0 && f3 == 7)   ua = 5'd10;
        else if (opc == 'h33 && f7 == 0 && f3 == 6)   ua = 5'd12;
        else if (opc == 'h33 && f7 == 0 && f3 == 4)   ua = 5'd14;
        else if (opc == 'h6F)                         begin ua = 5'd16; imm = jval; jal = 1'b1; end
        else legal = 1'b0;
    endfunction

    // Random word of a chosen legal instruction class
    function automatic logic [31:0] mk_legal(input int k);
        logic [31:0] w;
        w = $urandom;
        case (k)
            0: begin w[6:0] = 7'h03; w[14:12] = 3'd2; end
            1: begin w[6:0] = 7'h23; w[14:12] = 3'd2; end
            2: begin w[6:0] = 7'h33; w[14:12] = 3'd0; w[31:25] = 7'h00; end
            3: begin w[6:0] = 7'h33; w[14:12] = 3'd0; w[31:25] = 7'h20; end
            4: begin w[6:0] = 7'h13; w[14:12] = 3'd0; end
            5: begin w[6:0] = 7'h33; w[14:12] = 3'd7; w[31:25] = 7'h00; end
            6: begin w[6:0] = 7'h33; w[14:12] = 3'd6; w[31:25] = 7'h00; end
            7: begin w[6:0] = 7'h33; w[14:12] = 3'd4; w[31:25] = 7'h00; end
            default: w[6:0] = 7'h6F;
        endcase
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word for a single cycle, then let DECODE complete
    task automatic give(input logic [31:0] w);
        instr_valid = 1'b1;
        instr_data  = w;
        step();
        instr_valid = 1'b0;
        instr_data  = $urandom;
        step();
    endtask

    task automatic pulse_done();
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_valid = 1'b0; done = 1'b1; instr_data = 32'h0;
        step();
        step();
        done = 1'b0;
        checks++;
        if ({decode_addr, pc_reg, pc_plus4, instr_req} !== {5'd18, 32'd0, 32'd4, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got ua=%0d pc=%h p4=%h req=%b want ua=18 pc=0 p4=4 req=0",
                     decode_addr, pc_reg, pc_plus4, instr_req);
        end
        checks++;
        if ({rd_index, rs1_index, rs2_index, immediate, illegal_instr, timeout_err, halted} !== '0) begin
            errors++;
            $display("FAIL reset_fields got rd=%0d rs1=%0d rs2=%0d imm=%h ill=%b to=%b h=%b want all 0",
                     rd_index, rs1_index, rs2_index, immediate, illegal_instr, timeout_err, halted);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({instr_req, instr_addr} !== {1'b1, 32'd0}) begin
            errors++;
            $display("FAIL reset_release got req=%b addr=%h want req=1 addr=0", instr_req, instr_addr);
        end
        m_pc = 32'd0;
    endtask

    task automatic test_lw();
        give(32'h01412083);
        checks++;
        if ({decode_addr, rd_index, rs1_index, immediate} !== {5'd0, 5'd1, 5'd2, 32'd20}) begin
            errors++;
            $display("FAIL lw_fields got ua=%0d rd=%0d rs1=%0d imm=%h want 0 1 2 14",
                     decode_addr, rd_index, rs1_index, immediate);
        end
        step();
        step();
        pulse_done();
        checks++;
        if ({pc_reg, pc_plus4, instr_req, instr_addr, decode_addr} !== {32'd4, 32'd8, 1'b1, 32'd4, 5'd18}) begin
            errors++;
            $display("FAIL lw_advance got pc=%h p4=%h req=%b addr=%h ua=%0d want 4 8 1 4 18",
                     pc_reg, pc_plus4, instr_req, instr_addr, decode_addr);
        end
        m_pc = 32'd4;
    endtask

    task automatic test_sw();
        give(32'h00112A23);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({decode_addr, rs1_index, rs2_index, immediate, instr_req} !== {5'd2, 5'd2, 5'd1, 32'd20, 1'b0}) begin
                errors++;
                $display("FAIL sw_hold[%0d] got ua=%0d rs1=%0d rs2=%0d imm=%h req=%b want 2 2 1 14 0",
                         i, decode_addr, rs1_index, rs2_index, immediate, instr_req);
            end
            if (i < 4) step();
        end
        pulse_done();
        checks++;
        if (pc_reg !== 32'd8) begin
            errors++;
            $display("FAIL sw_advance got pc=%h want 8", pc_reg);
        end
        m_pc = 32'd8;
    endtask

    task automatic test_jal();
        give(32'hFF9FF0EF);
        checks++;
        if ({decode_addr, rd_index, immediate, pc_plus4} !== {5'd16, 5'd1, 32'hFFFF_FFF8, 32'd12}) begin
            errors++;
            $display("FAIL jal_fields got ua=%0d rd=%0d imm=%h p4=%h want 16 1 fffffff8 c",
                     decode_addr, rd_index, immediate, pc_plus4);
        end
        pulse_done();
        checks++;
        if ({pc_reg, pc_plus4} !== {32'd0, 32'd4}) begin
            errors++;
            $display("FAIL jal_target got pc=%h p4=%h want 0 4", pc_reg, pc_plus4);
        end
        m_pc = 32'd0;
    endtask

    task automatic test_illegal();
        give(32'h0000_0000);
        checks++;
        if ({illegal_instr, decode_addr, instr_req, instr_addr, halted} !== {1'b1, 5'd18, 1'b1, 32'd4, 1'b0}) begin
            errors++;
            $display("FAIL illegal_pulse got ill=%b ua=%0d req=%b addr=%h h=%b want 1 18 1 4 0",
                     illegal_instr, decode_addr, instr_req, instr_addr, halted);
        end
        step();
        checks++;
        if ({illegal_instr, instr_req, instr_addr} !== {1'b0, 1'b1, 32'd4}) begin
            errors++;
            $display("FAIL illegal_width got ill=%b req=%b addr=%h want 0 1 4",
                     illegal_instr, instr_req, instr_addr);
        end
        m_pc = 32'd4;
    endtask

    task automatic test_done_edges();
        // done while fetching must not move the PC
        pulse_done();
        step();
        checks++;
        if ({instr_req, instr_addr} !== {1'b1, m_pc}) begin
            errors++;
            $display("FAIL done_in_fetch got req=%b addr=%h want 1 %h", instr_req, instr_addr, m_pc);
        end
        // done on the last watchdog cycle still completes normally
        give(32'h00500093);
        repeat (TIMEOUT - 1) step();
        checks++;
        if ({halted, instr_req, decode_addr} !== {1'b0, 1'b0, 5'd8}) begin
            errors++;
            $display("FAIL wd_last_exec got h=%b req=%b ua=%0d want 0 0 8", halted, instr_req, decode_addr);
        end
        pulse_done();
        m_pc = m_pc + 32'd4;
        checks++;
        if ({timeout_err, halted, pc_reg, instr_req} !== {1'b0, 1'b0, m_pc, 1'b1}) begin
            errors++;
            $display("FAIL done_wins got to=%b h=%b pc=%h req=%b want 0 0 %h 1",
                     timeout_err, halted, pc_reg, instr_req, m_pc);
        end
    endtask

    task automatic test_random();
        logic [31:0] w, imm;
        logic [4:0]  ua;
        bit          legal, jal;
        for (int n = 0; n < 60; n++) begin
            w = ($urandom_range(0, 3) == 0) ? $urandom : mk_legal($urandom_range(0, 8));
            ref_decode(w, legal, ua, imm, jal);
            checks++;
            if ({instr_req, instr_addr} !== {1'b1, m_pc}) begin
                errors++;
                $display("FAIL rnd_fetch[%0d] got req=%b addr=%h want 1 %h", n, instr_req, instr_addr, m_pc);
            end
            give(w);
            if (legal) begin
                checks++;
                if ({decode_addr, rd_index, rs1_index, rs2_index, immediate, pc_plus4, illegal_instr} !==
                    {ua, w[11:7], w[19:15], w[24:20], imm, m_pc + 32'd4, 1'b0}) begin
                    errors++;
                    $display("FAIL rnd_dec[%0d] w=%h got ua=%0d rd=%0d rs1=%0d rs2=%0d imm=%h p4=%h want ua=%0d imm=%h p4=%h",
                             n, w, decode_addr, rd_index, rs1_index, rs2_index, immediate, pc_plus4,
                             ua, imm, m_pc + 32'd4);
                end
                repeat ($urandom_range(0, 6)) step();
                checks++;
                if ({decode_addr, immediate} !== {ua, imm}) begin
                    errors++;
                    $display("FAIL rnd_hold[%0d] got ua=%0d imm=%h want %0d %h", n, decode_addr, immediate, ua, imm);
                end
                pulse_done();
                m_pc = jal ? m_pc + imm : m_pc + 32'd4;
                checks++;
                if ({pc_reg, pc_plus4, decode_addr} !== {m_pc, m_pc + 32'd4, 5'd18}) begin
                    errors++;
                    $display("FAIL rnd_pc[%0d] got pc=%h p4=%h ua=%0d want %h %h 18",
                             n, pc_reg, pc_plus4, decode_addr, m_pc, m_pc + 32'd4);
                end
            end else begin
                m_pc = m_pc + 32'd4;
                checks++;
                if ({illegal_instr, decode_addr, instr_req, pc_reg} !== {1'b1, 5'd18, 1'b1, m_pc}) begin
                    errors++;
                    $display("FAIL rnd_illegal[%0d] w=%h got ill=%b ua=%0d req=%b pc=%h want 1 18 1 %h",
                             n, w, illegal_instr, decode_addr, instr_req, pc_reg, m_pc);
                end
                step();
            end
        end
    endtask

    task automatic test_timeout();
        give(32'h002081B3);
        checks++;
        if (decode_addr !== 5'd4) begin
            errors++;
            $display("FAIL to_add got ua=%0d want 4", decode_addr);
        end
        repeat (TIMEOUT - 1) step();
        checks++;
        if ({halted, timeout_err} !== 2'b00) begin
            errors++;
            $display("FAIL to_early got h=%b to=%b want 0 0", halted, timeout_err);
        end
        step();
        checks++;
        if ({halted, timeout_err, instr_req, decode_addr} !== {1'b1, 1'b1, 1'b0, 5'd18}) begin
            errors++;
            $display("FAIL to_halt got h=%b to=%b req=%b ua=%0d want 1 1 0 18",
                     halted, timeout_err, instr_req, decode_addr);
        end
        pulse_done();
        step();
        checks++;
        if ({halted, timeout_err, instr_req, pc_reg} !== {1'b1, 1'b1, 1'b0, m_pc}) begin
            errors++;
            $display("FAIL to_sticky got h=%b to=%b req=%b pc=%h want 1 1 0 %h",
                     halted, timeout_err, instr_req, pc_reg, m_pc);
        end
    endtask

    task automatic test_reset_mid_exec();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        m_pc = 32'd0;
        checks++;
        if ({timeout_err, halted, pc_reg, instr_req} !== {1'b0, 1'b0, m_pc, 1'b1}) begin
            errors++;
            $display("FAIL halt_reset got to=%b h=%b pc=%h req=%b want 0 0 0 1",
                     timeout_err, halted, pc_reg, instr_req);
        end
        give(32'h01412083);
        step();
        rst  = 1'b1;
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        rst = 1'b0;
        step();
        checks++;
        if ({pc_reg, pc_plus4, decode_addr, instr_req, timeout_err, halted} !==
            {32'd0, 32'd4, 5'd18, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL exec_reset got pc=%h p4=%h ua=%0d req=%b to=%b h=%b want 0 4 18 1 0 0",
                     pc_reg, pc_plus4, decode_addr, instr_req, timeout_err, halted);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_jal();
        test_illegal();
        test_done_edges();
        test_random();
        test_timeout();
        test_reset_mid_exec();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_decode_seq.md
Name: instr_decode_seq

Overview:
- Upstream issue stage for `top` (the column/row microcoded datapath).
- Fetches 32-bit RV32I-subset instruction words from instruction memory over a req/valid handshake.
- Decodes each word into the fields `top` consumes: decode_addr, rd/rs1/rs2 index, immediate, pc_reg, pc_plus4.
- Holds those fields stable until `top` pulses done, then advances the PC. Exactly one instruction is in flight at a time.

Parameters:
- COLS, 32, datapath/PC/immediate width (≥32)
- RESET_PC, 32'h0000_0000, PC loaded on reset
- TIMEOUT, 64, max cycles in EXEC waiting for done before error halt

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- instr_req  out  1  fetch request, held until instr_valid
- instr_addr  out  COLS  fetch address (= pc_reg)
- instr_valid  in  1  instr_data valid this cycle; ignored when instr_req=0
- instr_data  in  32  fetched instruction word
- done  in  1  `top` finished current microcode sequence
- decode_addr  out  5  microcode entry address to `top`
- rd_index  out  5  destination register
- rs1_index  out  5  source register 1
- rs2_index  out  5  source register 2
- immediate  out  COLS  sign-extended immediate
- pc_reg  out  COLS  PC of current instruction
- pc_plus4  out  COLS  pc_reg+4, mod 2^COLS
- illegal_instr  out  1  one-cycle pulse on unsupported opcode/funct
- timeout_err  out  1  sticky; set on done timeout
- halted  out  1  high in HALT

Behaviour:

Reset state (any cycle rst=1, including mid-EXEC):
- state=FETCH, pc_reg=RESET_PC, pc_plus4=RESET_PC+4.
- decode_addr=UADDR_WAIT (18).
- rd/rs1/rs2=0, immediate=0.
- instr_req=0 during reset, 1 from first cycle after.
- illegal_instr=0, timeout_err=0, halted=0.
- In-flight instruction is discarded; a done arriving during reset is ignored.

FETCH:
- instr_req=1, decode_addr=UADDR_WAIT.
- On instr_valid, register instr_data and go to DECODE next cycle.

DECODE (1 cycle):
- Register all output fields and the watchdog load, then go to EXEC.
- Decode map:
  - LW (opc 0000011, f3 010) → UADDR_LOAD=0
  - SW (0100011, 010) → UADDR_STORE=2
  - ADD (0110011, f3 000, f7 0000000) → 4
  - SUB (same, f7 0100000) → 6
  - ADDI (0010011, 000) → 8
  - AND (0110011, 111) → 10
  - OR (110) → 12
  - XOR (100) → 14
  - JAL (1101111) → 16
- Immediate formats, all sign-extended to COLS:
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - J: {[31],[19:12],[20],[30:21],0}
  - R: 0
- Index fields come from fixed bit positions regardless of type: rd [11:7], rs1 [19:15], rs2 [24:20].
- Unsupported word:
  - illegal_instr pulses for 1 cycle.
  - decode_addr stays UADDR_WAIT.
  - Skip EXEC; next pc = pc+4; go to FETCH.

EXEC:
- Outputs held constant.
- Watchdog counts up from 0 each cycle.
- On done=1: pc_reg ← (JAL ? pc_reg+immediate : pc_plus4), pc_plus4 ← new pc+4. decode_addr=UADDR_WAIT next cycle, then FETCH.
- If count reaches TIMEOUT-1 without done: timeout_err=1, go to HALT.
- done and the timeout boundary in the same cycle: done wins.
- done outside EXEC is ignored.

HALT:
- halted=1, instr_req=0, decode_addr=UADDR_WAIT.
- Exited only by rst.

Arithmetic:
- All PC arithmetic wraps mod 2^COLS.
- Misaligned JAL targets are not checked.

Minimum turnaround: FETCH(1 if instr_valid same cycle) + DECODE(1) + EXEC(≥1).

Decomposition:
- Package `isa_pkg`:
  - opcode/funct3/funct7 constants.
  - UADDR_* localparams (5-bit), including UADDR_WAIT=18.
  - state enum {FETCH, DECODE, EXEC, HALT}.
  - Struct `dec_fields_t` {uaddr, rd, rs1, rs2, imm, is_jal, illegal}.
- One sub-module, `instr_field_decode`: purely combinational, instr_data → dec_fields_t.
- The FSM, PC register and watchdog stay in `instr_decode_seq`.

Test Plan:
1. Reset with rst=1 for 2 cycles → decode_addr=18, pc_reg=0, pc_plus4=4, instr_req=0. First post-reset cycle → instr_req=1, instr_addr=0.
2. Return 0x01412083 (lw x1,20(x2)) → after DECODE: decode_addr=0, rd=1, rs1=2, immediate=20. Pulse done after 3 cycles → pc_reg=4, pc_plus4=8, instr_req=1 with instr_addr=4.
3. Return 0x00112A23 (sw x1,20(x2)) → decode_addr=2, rs1=2, rs2=1, immediate=20. Fields stable across 5 EXEC cycles until done.
4. At pc=8, return 0xFF9FF0EF (jal x1,-8) → decode_addr=16, rd=1, immediate=32'hFFFF_FFF8, pc_plus4=12. On done → pc_reg=0.
5. Return 0x0000_0000 → illegal_instr high for exactly 1 cycle, decode_addr stays 18, next instr_addr=pc+4, no EXEC entered.
6. Issue ADD (0x002081B3) and never assert done → timeout_err=1 and halted=1 after TIMEOUT EXEC cycles; a later done is ignored. Assert rst mid-EXEC on a fresh run → FETCH at RESET_PC, timeout_err cleared.
